// File: rtl/baud_rate_gen_hs_pkg.sv
// Shared UART clocking package: baud select encodings, nominal baud rates
// and the half-period helper used by the baud generator and the TX/RX blocks.
package baud_rate_gen_hs_pkg;

  // Encoding of the 2-bit rate select input.
  localparam logic [1:0] BAUD_921600 = 2'd0;
  localparam logic [1:0] BAUD_460800 = 2'd1;
  localparam logic [1:0] BAUD_230400 = 2'd2;
  localparam logic [1:0] BAUD_115200 = 2'd3;

  // Nominal line rates in baud, one per select code.
  localparam int RATE_921600 = 921_600;
  localparam int RATE_460800 = 460_800;
  localparam int RATE_230400 = 230_400;
  localparam int RATE_115200 = 115_200;

  // Number of system clocks in one half of a baud period, truncated.
  function automatic int half_period(input int clk_freq, input int baud);
    return clk_freq / (2 * baud);
  endfunction

endpackage

// File: rtl/baud_rate_gen_hs.sv
// High-speed UART baud clock generator. Produces a 50%-duty square wave at
// one of four rates; idles low while disabled or in reset. The output is a
// flop so downstream shift logic sees clean, glitch-free edges.
import baud_rate_gen_hs_pkg::*;

module baud_rate_gen_hs #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int CNT_W    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baudRate,
  input  logic       en,
  output logic       clkOut
);

  // Half-period lengths in clocks for each select code.
  localparam int H0 = half_period(CLK_FREQ, RATE_921600);
  localparam int H1 = half_period(CLK_FREQ, RATE_460800);
  localparam int H2 = half_period(CLK_FREQ, RATE_230400);
  localparam int H3 = half_period(CLK_FREQ, RATE_115200);

  // Terminal counter values: the counter runs 0..H-1 per half period.
  localparam logic [CNT_W-1:0] LIM0 = CNT_W'(H0 - 1);
  localparam logic [CNT_W-1:0] LIM1 = CNT_W'(H1 - 1);
  localparam logic [CNT_W-1:0] LIM2 = CNT_W'(H2 - 1);
  localparam logic [CNT_W-1:0] LIM3 = CNT_W'(H3 - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic             terminal;

  // Pick the terminal count for the current select; no latching, so a
  // rate change applies to the half period already in progress.
  always_comb begin
    limit = LIM3;
    case (baudRate)
      BAUD_921600: limit = LIM0;
      BAUD_460800: limit = LIM1;
      BAUD_230400: limit = LIM2;
      BAUD_115200: limit = LIM3;
      default:     limit = LIM3;
    endcase
  end

  // Greater-or-equal rather than equality: after a switch to a faster rate
  // the counter may already sit past the new limit, and must then toggle on
  // the next edge instead of wrapping through the full counter range.
  assign terminal = (cnt >= limit);

  // Half-period counter: cleared by reset, by a disabled cycle and at each
  // terminal count; otherwise advances by one per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (terminal) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Output toggle flop: forced low when disabled, flips at each terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkOut <= 1'b0;
    end else if (!en) begin
      clkOut <= 1'b0;
    end else if (terminal) begin
      clkOut <= ~clkOut;
    end
  end

endmodule

// File: tb/tb_baud_rate_gen_hs.sv
// Bench for baud_rate_gen_hs. Expected output levels come from a closed-form
// model: after m enabled edges at half period H, the output is (m / H) mod 2.
module tb_baud_rate_gen_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       clk_out;

  int total = 0;
  int bad   = 0;

  int rate_tab [4] = '{921600, 460800, 230400, 115200};

  always #5 clk = ~clk;

  baud_rate_gen_hs #(
    .CLK_FREQ(100_000_000),
    .CNT_W   (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .baudRate(sel),
    .en      (en),
    .clkOut  (clk_out)
  );

  function automatic int h_of(input int s);
    return 100_000_000 / (2 * rate_tab[s]);
  endfunction

  function automatic logic model_level(input int m, input int h);
    return ((m / h) % 2) == 1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3 rst = 1'b1;
    #1;
    total++;
    if (clk_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: clkOut=%b expected 0", clk_out);
    end
    #9 rst = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      total++;
      if (clk_out !== 1'b0) begin
        bad++;
        $display("FAIL idle_en0: clkOut=%b expected 0 at cycle %0d", clk_out, c);
      end
    end
  endtask

  task automatic test_first_rise;
    int h;
    int rise_at;
    h = h_of(3);
    rise_at = -1;
    sel = 2'd3;
    en  = 1'b1;
    for (int m = 1; m <= 2 * 2 * h + 10; m++) begin
      tick();
      total++;
      if (clk_out !== model_level(m, h)) begin
        bad++;
        $display("FAIL sel3_wave: clkOut=%b expected %b at enabled edge %0d", clk_out, model_level(m, h), m);
      end
      if (rise_at < 0 && clk_out === 1'b1) rise_at = m;
    end
    total++;
    if (rise_at != h) begin
      bad++;
      $display("FAIL sel3_first_rise: rose at edge %0d expected %0d", rise_at, h);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_rates;
    int order [3] = '{0, 1, 2};
    int j;
    int tmp;
    j = int'($urandom_range(0, 2));
    tmp = order[0]; order[0] = order[j]; order[j] = tmp;
    for (int i = 0; i < 3; i++) begin
      int s;
      int h;
      int run;
      int phases;
      int guard;
      logic level;
      s = order[i];
      h = h_of(s);
      en = 1'b0;
      tick();
      tick();
      sel = 2'(s);
      en  = 1'b1;
      level = 1'b0;
      run = 0;
      phases = 0;
      guard = 0;
      while (phases < 20 && guard < 25 * h) begin
        tick();
        guard++;
        run++;
        if (clk_out !== level) begin
          total++;
          if (run != h) begin
            bad++;
            $display("FAIL rate%0d_phase: length %0d expected %0d (phase %0d)", s, run, h, phases);
          end
          phases++;
          level = clk_out;
          run = 0;
        end
      end
      total++;
      if (phases < 20) begin
        bad++;
        $display("FAIL rate%0d_timeout: saw %0d phases expected 20", s, phases);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_random_drop;
    for (int it = 0; it < 6; it++) begin
      int s;
      int h;
      int k;
      s = (it == 0) ? 1 : int'($urandom_range(0, 3));
      h = h_of(s);
      k = (it == 0) ? h + h / 2 : int'($urandom_range(1, 3 * h));
      en = 1'b0;
      tick();
      sel = 2'(s);
      en  = 1'b1;
      for (int m = 1; m <= k; m++) begin
        tick();
        total++;
        if (clk_out !== model_level(m, h)) begin
          bad++;
          $display("FAIL drop_pre: clkOut=%b expected %b sel=%0d edge %0d", clk_out, model_level(m, h), s, m);
        end
      end
      en = 1'b0;
      for (int c = 0; c < 6; c++) begin
        tick();
        total++;
        if (clk_out !== 1'b0) begin
          bad++;
          $display("FAIL drop_low: clkOut=%b expected 0 sel=%0d cycle %0d", clk_out, s, c);
        end
      end
      en = 1'b1;
      for (int m = 1; m <= h + 5; m++) begin
        tick();
        total++;
        if (clk_out !== model_level(m, h)) begin
          bad++;
          $display("FAIL reenable: clkOut=%b expected %b sel=%0d edge %0d", clk_out, model_level(m, h), s, m);
        end
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_switch;
    int h3;
    int h0;
    logic exp;
    h3 = h_of(3);
    h0 = h_of(0);
    en = 1'b0;
    tick();
    sel = 2'd3;
    en  = 1'b1;
    for (int m = 1; m <= 300; m++) begin
      tick();
      total++;
      if (clk_out !== model_level(m, h3)) begin
        bad++;
        $display("FAIL switch_pre: clkOut=%b expected %b edge %0d", clk_out, model_level(m, h3), m);
      end
    end
    sel = 2'd0;
    for (int j = 0; j <= 4 * h0; j++) begin
      tick();
      exp = ~model_level(j, h0);
      total++;
      if (clk_out !== exp) begin
        bad++;
        $display("FAIL switch_post: clkOut=%b expected %b edge %0d after switch", clk_out, exp, j);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_async_reset;
    int s;
    int h;
    s = int'($urandom_range(0, 3));
    h = h_of(s);
    en = 1'b0;
    tick();
    sel = 2'(s);
    en  = 1'b1;
    for (int m = 1; m <= h + h / 2; m++) begin
      tick();
      total++;
      if (clk_out !== model_level(m, h)) begin
        bad++;
        $display("FAIL arst_pre: clkOut=%b expected %b sel=%0d edge %0d", clk_out, model_level(m, h), s, m);
      end
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (clk_out !== 1'b0) begin
      bad++;
      $display("FAIL arst_immediate: clkOut=%b expected 0", clk_out);
    end
    tick();
    total++;
    if (clk_out !== 1'b0) begin
      bad++;
      $display("FAIL arst_dominates_en: clkOut=%b expected 0", clk_out);
    end
    #3 rst = 1'b0;
    for (int m = 1; m <= 2 * h + 3; m++) begin
      tick();
      total++;
      if (clk_out !== model_level(m, h)) begin
        bad++;
        $display("FAIL arst_post: clkOut=%b expected %b sel=%0d edge %0d", clk_out, model_level(m, h), s, m);
      end
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_rise();
    test_rates();
    test_random_drop();
    test_switch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
